bc_feature_loader: RTL and testbench

BC_FEATURE_LOADER -- requirements
Module: bc_feature_loader

---
 rtl/bc_feature_loader.sv | 132 +++++++++++++
 tb/tb_bc_feature_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bc_feature_loader.sv
// Feature loader: quantizes nine raw features, holds them for a combinational classifier, and captures its decision.
// Optional build macro BC_LOADER_RANGE_CHECK_EN drops samples that contain an input value outside 1..10.
module bc_feature_loader #(
  parameter logic [3:0] Q_T1 = 4'd3,
  parameter logic [3:0] Q_T2 = 4'd5,
  parameter logic [3:0] Q_T3 = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_data,
  input  logic        in_last,
  output logic [17:0] feat_out,
  input  logic        cls_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_class,
  output logic        err
);

  typedef enum logic [1:0] {LOAD, EVAL, HOLD} state_t;

  state_t     state_reg;
  logic [3:0] index_reg;
  logic       in_ready_reg;
  logic       out_valid_reg;
  logic       out_class_reg;
  logic       err_reg;
  logic [1:0] slot_reg [9];
  logic [1:0] q;
  logic       xfer;
  logic       frame_err;
  logic       range_bad;
  logic       drop;

  always_comb begin
    q = 2'd0;
    if (in_data >= Q_T3)      q = 2'd3;
    else if (in_data >= Q_T2) q = 2'd2;
    else if (in_data >= Q_T1) q = 2'd1;
  end

  // in_ready_reg is high only in LOAD, so a transfer implies the LOAD state.
  assign xfer      = in_valid && in_ready_reg;
  assign frame_err = in_last ? (index_reg != 4'd8) : (index_reg == 4'd8);

`ifdef BC_LOADER_RANGE_CHECK_EN
  logic bad_seen_reg;
  logic cur_bad;

  assign cur_bad   = (in_data == 4'd0) || (in_data > 4'd10);
  assign range_bad = in_last && (bad_seen_reg || cur_bad);

  // A bad value is remembered until the sample closes, either by in_last or by a ninth feature.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_seen_reg <= 1'b0;
    end else if (xfer) begin
      if (in_last || index_reg == 4'd8) bad_seen_reg <= 1'b0;
      else                              bad_seen_reg <= bad_seen_reg | cur_bad;
    end
  end
`else
  assign range_bad = 1'b0;
`endif

  assign drop = frame_err || range_bad;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) slot_reg[gi] <= 2'd0;
        else if (xfer && index_reg == 4'(gi)) slot_reg[gi] <= q;
      end
      assign feat_out[2*gi +: 2] = slot_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= LOAD;
      index_reg     <= 4'd0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_class_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (xfer) begin
            if (drop) begin
              index_reg <= 4'd0;
              err_reg   <= 1'b1;
            end else if (in_last) begin
              index_reg    <= 4'd0;
              state_reg    <= EVAL;
              in_ready_reg <= 1'b0;
            end else begin
              index_reg <= index_reg + 4'd1;
            end
          end
        end
        EVAL: begin
          out_class_reg <= cls_in;
          out_valid_reg <= 1'b1;
          state_reg     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= LOAD;
          end
        end
        default: begin
          state_reg     <= LOAD;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_class = out_class_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_bc_feature_loader.sv
// Bench for bc_feature_loader: fixed vector table, hand-written corner sequences, and random samples against a reference model.
// Expectations follow BC_LOADER_RANGE_CHECK_EN when the bench is built with that macro.
module tb_bc_feature_loader;

  localparam logic [3:0] T1 = 4'd3;
  localparam logic [3:0] T2 = 4'd5;
  localparam logic [3:0] T3 = 4'd8;

  typedef logic [8:0][3:0] feat9_t;
  typedef struct packed {
    feat9_t      d;
    logic [17:0] feat;
    logic        cls;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = 4'd0;
  logic        in_last = 1'b0;
  logic [17:0] feat_out;
  logic        cls_in;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_class;
  logic        err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bc_feature_loader #(.Q_T1(T1), .Q_T2(T2), .Q_T3(T3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .feat_out  (feat_out),
    .cls_in    (cls_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .err       (err)
  );

  // Reference classifier: positive when the quantized features add up to 15 or more.
  function automatic logic cls_of(input logic [17:0] f);
    int s = 0;
    for (int k = 0; k < 9; k++) s += int'(f[2*k +: 2]);
    return (s >= 15);
  endfunction

  assign cls_in = cls_of(feat_out);

  function automatic feat9_t pack9(input int v0, input int v1, input int v2, input int v3,
                                   input int v4, input int v5, input int v6, input int v7, input int v8);
    feat9_t r;
    r[0] = 4'(v0); r[1] = 4'(v1); r[2] = 4'(v2); r[3] = 4'(v3); r[4] = 4'(v4);
    r[5] = 4'(v5); r[6] = 4'(v6); r[7] = 4'(v7); r[8] = 4'(v8);
    return r;
  endfunction

  // A sample is the features up to last_pos; it only classifies if it has exactly nine.
  function automatic void model(input feat9_t d, input int last_pos,
                                output logic [17:0] f, output logic c, output logic dr);
    f  = '0;
    dr = (last_pos != 8);
    for (int k = 0; k <= last_pos; k++) begin
      int v;
      int qv;
      v = int'(d[k]);
      if (v >= int'(T3))      qv = 3;
      else if (v >= int'(T2)) qv = 2;
      else if (v >= int'(T1)) qv = 1;
      else                    qv = 0;
      f[2*k +: 2] = 2'(qv);
`ifdef BC_LOADER_RANGE_CHECK_EN
      if (v == 0 || v > 10) dr = 1'b1;
`endif
    end
    c = cls_of(f);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic feed(input logic [3:0] d, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("feed_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_sample(input string tag, input feat9_t d, input int last_pos,
                            input logic [17:0] ef, input logic ec, input logic edrop,
                            input logic release_hold);
    for (int k = 0; k <= last_pos; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      feed(d[k], k == last_pos);
      if (k < last_pos) check({tag, "_err_mid"}, 32'(err), 32'(0));
    end
    if (edrop) begin
      check({tag, "_err_pulse"}, 32'(err), 32'(1));
      check({tag, "_drop_novalid"}, 32'(out_valid), 32'(0));
      check({tag, "_drop_ready"}, 32'(in_ready), 32'(1));
      @(posedge clk); #1;
      check({tag, "_err_end"}, 32'(err), 32'(0));
      check({tag, "_drop_novalid2"}, 32'(out_valid), 32'(0));
      $display("sample %s: dropped, err=%0b", tag, err);
    end else begin
      check({tag, "_eval_ready"}, 32'(in_ready), 32'(0));
      check({tag, "_eval_valid"}, 32'(out_valid), 32'(0));
      check({tag, "_eval_err"}, 32'(err), 32'(0));
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'(1));
      check({tag, "_feat"}, 32'(feat_out), 32'(ef));
      check({tag, "_class"}, 32'(out_class), 32'(ec));
      $display("sample %s: feat_out=%05h out_class=%0b", tag, feat_out, out_class);
      if (release_hold) begin
        @(posedge clk); #1;
        check({tag, "_release_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_release_ready"}, 32'(in_ready), 32'(1));
      end
    end
  endtask

  rec_t        tbl [6];
  feat9_t      d;
  logic [17:0] ef;
  logic        ec;
  logic        edrop;

  initial begin
    tbl[0] = '{d: pack9(1, 2, 3, 4, 5, 6, 7, 8, 10), feat: 18'b11_11_10_10_10_01_01_00_00, cls: 1'b0};
    tbl[1] = '{d: pack9(2, 3, 4, 5, 7, 8, 1, 9, 10), feat: 18'b11_11_00_11_10_10_01_01_00, cls: 1'b1};
    tbl[2] = '{d: pack9(1, 1, 1, 1, 1, 1, 1, 1, 1),  feat: 18'h00000, cls: 1'b0};
    tbl[3] = '{d: pack9(9, 9, 9, 9, 9, 9, 9, 9, 9),  feat: 18'h3FFFF, cls: 1'b1};
    tbl[4] = '{d: pack9(5, 5, 5, 5, 5, 5, 5, 5, 5),  feat: 18'h2AAAA, cls: 1'b1};
    tbl[5] = '{d: pack9(3, 4, 2, 8, 6, 1, 5, 7, 9),  feat: 18'b11_10_10_00_10_11_00_01_01, cls: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_feat", 32'(feat_out), 32'(0));
    check("rst_class", 32'(out_class), 32'(0));
    check("rst_err", 32'(err), 32'(0));

    for (int i = 0; i < 6; i++)
      run_sample($sformatf("tbl%0d", i), tbl[i].d, 8, tbl[i].feat, tbl[i].cls, 1'b0, 1'b1);

    // Early in_last on the 4th feature, then a clean sample.
    run_sample("short", tbl[1].d, 3, 18'h0, 1'b0, 1'b1, 1'b1);
    run_sample("after_short", tbl[0].d, 8, tbl[0].feat, tbl[0].cls, 1'b0, 1'b1);

    // Consumer stalls in HOLD while the producer keeps offering data.
    out_ready = 1'b0;
    run_sample("stall", tbl[1].d, 8, tbl[1].feat, tbl[1].cls, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'd9;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'(1));
      check("stall_ready", 32'(in_ready), 32'(0));
      check("stall_class", 32'(out_class), 32'(tbl[1].cls));
      check("stall_feat", 32'(feat_out), 32'(tbl[1].feat));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    @(posedge clk); #1;
    check("stall_release_valid", 32'(out_valid), 32'(0));
    check("stall_release_ready", 32'(in_ready), 32'(1));
    run_sample("after_stall", tbl[5].d, 8, tbl[5].feat, tbl[5].cls, 1'b0, 1'b1);

    // Reset in the middle of a sample.
    for (int k = 0; k < 5; k++) feed(tbl[3].d[k], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_err", 32'(err), 32'(0));
    check("midrst_feat", 32'(feat_out), 32'(0));
    check("midrst_ready", 32'(in_ready), 32'(1));
    run_sample("after_rst", tbl[2].d, 8, tbl[2].feat, tbl[2].cls, 1'b0, 1'b1);
    check("after_rst_err", 32'(err), 32'(0));

    // Reset while a result is pending in HOLD.
    out_ready = 1'b0;
    run_sample("hold_rst", tbl[3].d, 8, tbl[3].feat, tbl[3].cls, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("holdrst_valid", 32'(out_valid), 32'(0));
    check("holdrst_class", 32'(out_class), 32'(0));
    check("holdrst_err", 32'(err), 32'(0));

    // Out-of-range zero at feature 3.
    d = pack9(1, 2, 3, 0, 5, 6, 7, 8, 10);
    model(d, 8, ef, ec, edrop);
`ifdef BC_LOADER_RANGE_CHECK_EN
    check("range_model_drop", 32'(edrop), 32'(1));
`else
    check("range_model_slot3", 32'(ef[7:6]), 32'(0));
`endif
    run_sample("range0", d, 8, ef, ec, edrop, 1'b1);

    for (int n = 0; n < 25; n++) begin
      int lp;
      for (int k = 0; k < 9; k++)
        d[k] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 10));
      lp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 8;
      model(d, lp, ef, ec, edrop);
      run_sample($sformatf("rnd%0d", n), d, lp, ef, ec, edrop, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
